demodulator: RTL and testbench
==============================

DEMODULATOR -- requirements
Module: demodulator

Interface
REQ-001 SHALL expose parameter DIV, default 50: clock cycles per sample tick.
REQ-002 SHALL expose parameter GUARD_MIN, default 400: minimum low ticks that arm frame detection.
REQ-003 SHALL expose parameter HIGH_MIN, default 5200: minimum accepted high-burst length, in ticks.
REQ-004 SHALL expose parameter HIGH_MAX, default 5900: maximum accepted high-burst length, in ticks.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port enable, input, 1 bit: receiver active while high.
REQ-008 SHALL have port rx_signal, input, 1 bit: asynchronous OOK line from the modulated link.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when an accepted frame ends.
REQ-010 SHALL have port frame_error, output, 1 bit: one-cycle pulse when a high burst falls outside [HIGH_MIN, HIGH_MAX].
REQ-011 SHALL have port high_ticks, output, 16 bits: length of the last completed high burst, in ticks.
REQ-012 SHALL have port busy, output, 1 bit: high while in state HIGH_MEAS.

Function
REQ-013 SHALL pass rx_signal through a 2-flop synchronizer before any use.
REQ-014 SHALL generate a tick once every DIV clocks while enable=1, using a prescaler that counts 0..DIV-1 and wraps.
REQ-015 SHALL hold the prescaler at 0 while enable=0.
REQ-016 SHALL sample the synchronized line and advance the state machine only on tick cycles.
REQ-017 SHALL implement states IDLE, ARM, HIGH_MEAS and WAIT_LOW.
REQ-018 IDLE: on enable=1, SHALL go to ARM with low_cnt=0.
REQ-019 ARM: low sample SHALL increment low_cnt, saturating at 16'hFFFF.
REQ-020 ARM: high sample with low_cnt>=GUARD_MIN SHALL go to HIGH_MEAS with hi_cnt=1.
REQ-021 ARM: high sample with low_cnt<GUARD_MIN SHALL go to WAIT_LOW with no output pulse.
REQ-022 HIGH_MEAS: high sample SHALL increment hi_cnt.
REQ-023 HIGH_MEAS: when hi_cnt would exceed HIGH_MAX, SHALL pulse frame_error, load high_ticks=HIGH_MAX+1 and go to WAIT_LOW.
REQ-024 HIGH_MEAS: low sample SHALL load high_ticks=hi_cnt.
REQ-025 HIGH_MEAS: on that low sample, SHALL pulse frame_valid if hi_cnt>=HIGH_MIN, otherwise frame_error.
REQ-026 HIGH_MEAS: on that low sample, SHALL go to ARM with low_cnt=1.
REQ-027 WAIT_LOW: low sample SHALL go to ARM with low_cnt=1.
REQ-028 frame_valid and frame_error SHALL be registered and assert in the cycle after the deciding tick cycle.
REQ-029 frame_valid and frame_error SHALL never assert in the same cycle.
REQ-030 enable=0 in any state SHALL force IDLE next cycle and clear low_cnt and hi_cnt.
REQ-031 enable=0 SHALL suppress frame_valid and frame_error; high_ticks SHALL hold its value.
REQ-032 Deassertion of enable mid-burst SHALL produce no pulse.
REQ-033 high_ticks SHALL change only when frame_valid or frame_error pulses.

Reset
REQ-034 reset=1 at a clock edge SHALL set state=IDLE and clear the prescaler, low_cnt, hi_cnt and the synchronizer flops.
REQ-035 reset=1 at a clock edge SHALL set frame_valid=0, frame_error=0, high_ticks=0 and busy=0.
REQ-036 reset SHALL take priority over enable and over any tick.
REQ-037 Reset mid-frame SHALL discard the frame and generate no pulse.

Structure
REQ-038 Package demod_pkg SHALL hold the state enum and the default values of DIV, GUARD_MIN, HIGH_MIN and HIGH_MAX.
REQ-039 The prescaler SHALL be a sub-module tick_divider (inputs clock, reset, enable; output tick) parameterized by DIV.

Verification
REQ-040 Line low 449 ticks, then high 5552 ticks, then low -> exactly one frame_valid, high_ticks in 5551..5553, busy high for the burst.
REQ-041 Line low 100 ticks, then high 5552 ticks -> no pulses, state WAIT_LOW, then ARM after the line goes low.
REQ-042 Line low 449 ticks, then high 3000 ticks -> frame_error on the falling-edge tick, high_ticks about 3000.
REQ-043 Line low 449 ticks, then held high -> frame_error when hi_cnt passes 5900, high_ticks=5901, no frame_valid.
REQ-044 enable dropped at 2000 ticks into a burst, or reset pulsed at 2000 ticks -> no pulse, IDLE next cycle, reset also clears high_ticks to 0.
REQ-045 Two back-to-back valid frames (449 low / 5552 high each) -> two frame_valid pulses, high_ticks updated each time.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared types, default parameter values and helpers for the OOK frame demodulator.
package demod_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    HIGH_MEAS = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  localparam int DIV_DEF       = 50;
  localparam int GUARD_MIN_DEF = 400;
  localparam int HIGH_MIN_DEF  = 5200;
  localparam int HIGH_MAX_DEF  = 5900;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Sample-tick prescaler: counts 0..DIV-1 while enabled, pulses tick on the wrap.
module tick_divider #(
  parameter int DIV = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || cnt_q == LAST) cnt_d = '0;
    else                          cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/demodulator.sv
// OOK frame demodulator: measures high bursts that follow a long-enough low guard
// interval and flags them as valid frames or errors according to their length.
module demodulator
  import demod_pkg::*;
#(
  parameter int DIV       = DIV_DEF,
  parameter int GUARD_MIN = GUARD_MIN_DEF,
  parameter int HIGH_MIN  = HIGH_MIN_DEF,
  parameter int HIGH_MAX  = HIGH_MAX_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx_signal,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [15:0] high_ticks,
  output logic        busy
);

  localparam logic [15:0] GUARD_L   = 16'(GUARD_MIN);
  localparam logic [15:0] HMIN_L    = 16'(HIGH_MIN);
  localparam logic [15:0] HMAX_L    = 16'(HIGH_MAX);
  localparam logic [15:0] HOVER_L   = 16'(HIGH_MAX + 1);

  logic        tick;
  logic        sync1_q, sync2_q;
  state_e      state_q, state_d;
  logic [15:0] low_q, low_d;
  logic [15:0] hi_q, hi_d;
  logic        fv_q, fv_d;
  logic        fe_q, fe_d;
  logic [15:0] ht_q, ht_d;

  tick_divider #(.DIV(DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    hi_d    = hi_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    ht_d    = ht_q;
    if (!enable) begin
      state_d = IDLE;
      low_d   = '0;
      hi_d    = '0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          low_d   = '0;
        end
        ARM: begin
          if (!sync2_q) begin
            low_d = sat_inc16(low_q);
          end else if (low_q >= GUARD_L) begin
            state_d = HIGH_MEAS;
            hi_d    = 16'd1;
          end else begin
            state_d = WAIT_LOW;
          end
        end
        HIGH_MEAS: begin
          if (sync2_q) begin
            // Overlong burst is cut off as soon as the count would pass HIGH_MAX.
            if (hi_q >= HMAX_L) begin
              fe_d    = 1'b1;
              ht_d    = HOVER_L;
              hi_d    = '0;
              state_d = WAIT_LOW;
            end else begin
              hi_d = sat_inc16(hi_q);
            end
          end else begin
            ht_d    = hi_q;
            fv_d    = (hi_q >= HMIN_L);
            fe_d    = (hi_q <  HMIN_L);
            state_d = ARM;
            low_d   = 16'd1;
          end
        end
        WAIT_LOW: begin
          if (!sync2_q) begin
            state_d = ARM;
            low_d   = 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      low_q   <= '0;
      hi_q    <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ht_q    <= '0;
    end else begin
      sync1_q <= rx_signal;
      sync2_q <= sync1_q;
      state_q <= state_d;
      low_q   <= low_d;
      hi_q    <= hi_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      ht_q    <= ht_d;
    end
  end

  assign frame_valid = fv_q;
  assign frame_error = fe_q;
  assign high_ticks  = ht_q;
  assign busy        = (state_q == HIGH_MEAS);

endmodule

// File: tb/tb_demodulator.sv
// Directed bench for the demodulator using scaled-down timing parameters.
module tb_demodulator;
  import demod_pkg::*;

  localparam int DIV  = 4;
  localparam int GMIN = 10;
  localparam int HMIN = 20;
  localparam int HMAX = 30;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        rx_signal = 1'b0;
  logic        frame_valid, frame_error, busy;
  logic [15:0] high_ticks;

  int checks = 0;
  int errors = 0;
  int fv_total = 0;
  int fe_total = 0;
  int both_total = 0;

  demodulator #(
    .DIV(DIV), .GUARD_MIN(GMIN), .HIGH_MIN(HMIN), .HIGH_MAX(HMAX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rx_signal   (rx_signal),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .high_ticks  (high_ticks),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_valid) fv_total++;
    if (frame_error) fe_total++;
    if (frame_valid && frame_error) both_total++;
  end

  task automatic clocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic line(input logic lvl, input int nticks);
    rx_signal = lvl;
    clocks(nticks * DIV);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clocks(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", frame_error); end
    checks++; if (high_ticks !== 16'd0) begin errors++; $display("FAIL reset_ht got %0d want 0", high_ticks); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_valid();
    int fv0, fe0;
    fv0 = fv_total; fe0 = fe_total;
    enable = 1'b1;
    line(1'b0, 15);
    line(1'b1, 12);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL valid_busy got %b want 1", busy); end
    line(1'b1, 13);
    line(1'b0, 3);
    checks++; if (fv_total - fv0 !== 1) begin errors++; $display("FAIL valid_fv_count got %0d want 1", fv_total - fv0); end
    checks++; if (fe_total - fe0 !== 0) begin errors++; $display("FAIL valid_fe_count got %0d want 0", fe_total - fe0); end
    checks++; if (high_ticks < 16'd24 || high_ticks > 16'd26) begin errors++; $display("FAIL valid_ht got %0d want 24..26", high_ticks); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL valid_busy_after got %b want 0", busy); end
  endtask

  task automatic test_short_guard();
    int fv0, fe0;
    do_reset();
    fv0 = fv_total; fe0 = fe_total;
    enable = 1'b1;
    line(1'b0, 3);
    line(1'b1, 25);
    checks++; if (fv_total - fv0 + fe_total - fe0 !== 0) begin errors++; $display("FAIL guard_pulses got %0d want 0", fv_total - fv0 + fe_total - fe0); end
    checks++; if (dut.state_q !== WAIT_LOW) begin errors++; $display("FAIL guard_state got %0d want WAIT_LOW", dut.state_q); end
    line(1'b0, 2);
    checks++; if (dut.state_q !== ARM) begin errors++; $display("FAIL guard_arm got %0d want ARM", dut.state_q); end
    checks++; if (high_ticks !== 16'd0) begin errors++; $display("FAIL guard_ht got %0d want 0", high_ticks); end
  endtask

  task automatic test_short_burst();
    int fv0, fe0;
    do_reset();
    fv0 = fv_total; fe0 = fe_total;
    enable = 1'b1;
    line(1'b0, 15);
    line(1'b1, 12);
    line(1'b0, 3);
    checks++; if (fe_total - fe0 !== 1) begin errors++; $display("FAIL short_fe got %0d want 1", fe_total - fe0); end
    checks++; if (fv_total - fv0 !== 0) begin errors++; $display("FAIL short_fv got %0d want 0", fv_total - fv0); end
    checks++; if (high_ticks < 16'd11 || high_ticks > 16'd13) begin errors++; $display("FAIL short_ht got %0d want 11..13", high_ticks); end
  endtask

  task automatic test_overlong();
    int fv0, fe0;
    do_reset();
    fv0 = fv_total; fe0 = fe_total;
    enable = 1'b1;
    line(1'b0, 15);
    line(1'b1, 40);
    checks++; if (fe_total - fe0 !== 1) begin errors++; $display("FAIL long_fe got %0d want 1", fe_total - fe0); end
    checks++; if (fv_total - fv0 !== 0) begin errors++; $display("FAIL long_fv got %0d want 0", fv_total - fv0); end
    checks++; if (high_ticks !== 16'(HMAX + 1)) begin errors++; $display("FAIL long_ht got %0d want %0d", high_ticks, HMAX + 1); end
    checks++; if (dut.state_q !== WAIT_LOW) begin errors++; $display("FAIL long_state got %0d want WAIT_LOW", dut.state_q); end
    line(1'b0, 3);
  endtask

  task automatic test_enable_drop();
    int fv0, fe0;
    fv0 = fv_total; fe0 = fe_total;
    line(1'b0, 15);
    line(1'b1, 10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL endrop_busy got %b want 1", busy); end
    enable = 1'b0;
    clocks(1);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL endrop_state got %0d want IDLE", dut.state_q); end
    line(1'b0, 3);
    checks++; if (fv_total - fv0 + fe_total - fe0 !== 0) begin errors++; $display("FAIL endrop_pulses got %0d want 0", fv_total - fv0 + fe_total - fe0); end
    checks++; if (high_ticks !== 16'(HMAX + 1)) begin errors++; $display("FAIL endrop_ht got %0d want %0d", high_ticks, HMAX + 1); end
  endtask

  task automatic test_reset_mid();
    int fv0, fe0;
    fv0 = fv_total; fe0 = fe_total;
    enable = 1'b1;
    line(1'b0, 15);
    line(1'b1, 10);
    reset = 1'b1;
    clocks(1);
    reset = 1'b0;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d want IDLE", dut.state_q); end
    checks++; if (high_ticks !== 16'd0) begin errors++; $display("FAIL rstmid_ht got %0d want 0", high_ticks); end
    line(1'b1, 5);
    line(1'b0, 3);
    checks++; if (fv_total - fv0 + fe_total - fe0 !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d want 0", fv_total - fv0 + fe_total - fe0); end
  endtask

  task automatic test_back_to_back();
    int fv0;
    do_reset();
    fv0 = fv_total;
    enable = 1'b1;
    line(1'b0, 15);
    line(1'b1, 25);
    line(1'b0, 15);
    checks++; if (high_ticks < 16'd24 || high_ticks > 16'd26) begin errors++; $display("FAIL b2b_ht1 got %0d want 24..26", high_ticks); end
    line(1'b1, 22);
    line(1'b0, 3);
    checks++; if (high_ticks < 16'd21 || high_ticks > 16'd23) begin errors++; $display("FAIL b2b_ht2 got %0d want 21..23", high_ticks); end
    checks++; if (fv_total - fv0 !== 2) begin errors++; $display("FAIL b2b_fv got %0d want 2", fv_total - fv0); end
    checks++; if (both_total !== 0) begin errors++; $display("FAIL both_pulses got %0d want 0", both_total); end
  endtask

  initial begin
    clocks(1);
    test_reset();
    test_valid();
    test_short_guard();
    test_short_burst();
    test_overlong();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
